mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage ARM-subset pipeline. It sits between the EXE stage outputs and the WB stage.
- Holds the word-organised data memory and performs LDR/STR accesses with a parameterised multi-cycle latency.
- Drives a freeze request upstream while an access is in flight.
- Contains the MEM/WB pipeline register that feeds the WB stage (wb enable, mem-read select, ALU result, memory data, destination).

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory.
- BASE_ADDR, 1024, byte address mapped to word 0.
- ACCESS_LATENCY, 4, cycles per load/store (>=1). A value of 1 means no stall.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous active-high reset.
- wb_enable_in  input  1  EXE/MEM writeback enable.
- mem_read_enable_in  input  1  load request.
- mem_write_enable_in  input  1  store request.
- alu_result_in  input  32  effective byte address, or the ALU result for non-memory ops.
- val_rm_in  input  32  store data.
- dest_in  input  4  destination register.
- wb_enable_out  output  1  MEM/WB writeback enable.
- mem_read_enable_out  output  1  MEM/WB result select (1 = memory data).
- alu_result_out  output  32  MEM/WB ALU result.
- mem_data_out  output  32  MEM/WB load data.
- dest_out  output  4  MEM/WB destination register.
- mem_freeze  output  1  freeze request to the IF/ID/EXE registers and the PC.
- addr_error  output  1  sticky flag: an out-of-range access occurred.

Behaviour:
- Reset is synchronous on the clk rising edge while rst=1.
  - All outputs become 0, the FSM goes to IDLE and the counter clears.
  - addr_error clears.
  - Memory contents are NOT cleared.
  - A rst asserted mid-access aborts the access with no memory write; mem_freeze is 0 in the following cycle.
- Address decode:
  - word_idx = (alu_result_in - BASE_ADDR) >> 2; address bits [1:0] are ignored.
  - An address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS.
- An op is a memory op iff mem_read_enable_in | mem_write_enable_in.
- FSM states: IDLE, ACCESS.
  - IDLE, no memory op:
    - mem_freeze=0.
    - MEM/WB register loads inputs every cycle (pass-through, 1-cycle latency); mem_data_out loads 0.
  - IDLE, memory op, ACCESS_LATENCY=1:
    - Access completes this cycle and mem_freeze=0.
    - Behaves like pass-through, plus the memory write or read.
  - IDLE, memory op, ACCESS_LATENCY>1:
    - Go to ACCESS with cnt=ACCESS_LATENCY-2.
    - mem_freeze=1 combinationally in this same cycle.
    - MEM/WB register loads a bubble: wb_enable_out=0, mem_read_enable_out=0, other fields 0.
  - ACCESS, cnt!=0: cnt decrements, mem_freeze=1, MEM/WB register loads a bubble.
  - ACCESS, cnt==0 (final cycle):
    - mem_freeze=0.
    - Store: writes val_rm_in to mem[word_idx] at this edge.
    - Load: mem_data_out <= mem[word_idx].
    - MEM/WB register loads the real inputs. Return to IDLE.
- Total latency from memory op arrival to MEM/WB valid is ACCESS_LATENCY cycles. mem_freeze is high for exactly ACCESS_LATENCY-1 cycles.
- Input stability: upstream holds all inputs stable while mem_freeze=1. The block samples the address and data only in the final cycle.
- Out-of-range access:
  - No write occurs; a load returns 0.
  - addr_error is set and stays set until reset.
  - Timing is otherwise unchanged.
- Read and write both high: the write is performed, and mem_data_out returns the pre-write word (read-before-write).
- Back-to-back memory ops: a second op arriving in the cycle after completion starts a new full ACCESS_LATENCY sequence. There is no pipelining of accesses.
- The memory is a plain register array, read combinationally inside the final cycle. There is no reset initialisation.

Decomposition:
- Shared pipeline package: FSM state typedef {IDLE, ACCESS}, the BASE_ADDR default, and the word/register width constants (32, 4).
- One natural sub-module, data_memory: a single-port register array with synchronous write, asynchronous read and a range check.
- The FSM, counter and MEM/WB register stay in mem_stage.

Test Plan:
- Non-memory op: alu_result_in=0x55, dest_in=3, wb_enable_in=1, latency 4 → next cycle alu_result_out=0x55, dest_out=3, wb_enable_out=1, mem_freeze never asserted.
- Store then load at latency 4:
  - STR val_rm_in=0xDEADBEEF to addr 1028 → mem_freeze high for 3 cycles, then wb_enable_out of a store is forwarded as given.
  - LDR from 1028 → 3 freeze cycles, then mem_data_out=0xDEADBEEF with mem_read_enable_out=1.
  - Bubbles (wb_enable_out=0) appear on every stalled cycle.
- ACCESS_LATENCY=1 build: STR 7 to 1024 then LDR 1024 on consecutive cycles → zero freeze cycles, load returns 7.
- Out-of-range access: LDR at 1024+4*MEM_WORDS=1280 → mem_data_out=0 and addr_error=1 sticky. Then STR to 1000 → memory unchanged and addr_error still 1.
- Reset mid-access: rst=1 during the 2nd freeze cycle of an STR of 0x1234 to 1032 → all outputs 0 and mem_freeze=0 next cycle. A later LDR 1032 returns the old content, not 0x1234.
- Aligned/misaligned addressing and read+write: STR 0xA to addr 1030 → a load from 1028 returns 0xA. With read+write both high writing 0xB to 1028 → mem_data_out=0xA, and a subsequent load returns 0xB.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage of the 5-stage ARM-subset pipeline.
//   - WORD_W / REG_W : data word width and register-index width
//   - DEFAULT_BASE_ADDR : byte address mapped to data-memory word 0
//   - mem_state_e : memory-stage access FSM states
package mem_stage_pkg;

  localparam int WORD_W            = 32;
  localparam int REG_W             = 4;
  localparam int DEFAULT_BASE_ADDR = 1024;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data memory used by the memory stage.
// Single port: synchronous write, asynchronous read and an address range check.
// Contents are never reset.
// Ports:
//   clk        : clock for the write port
//   write_en_i : write strobe; it is ignored for out-of-range addresses
//   addr_i     : byte address; bits [1:0] are ignored
//   wdata_i    : write data
//   rdata_o    : word at addr_i, or 0 when the address is out of range
//   in_range_o : 1 when BASE_ADDR <= addr_i < BASE_ADDR + 4*MEM_WORDS
module mem_stage_data_memory
  import mem_stage_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              write_en_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              in_range_o
);

  localparam int                IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [WORD_W-1:0] BASE_W = WORD_W'(BASE_ADDR);
  localparam logic [WORD_W-1:0] SPAN_W = WORD_W'(4 * MEM_WORDS);

  logic [WORD_W-1:0] mem_q [MEM_WORDS];
  logic [WORD_W-1:0] offset_s;
  logic [IDX_W-1:0]  idx_s;
  logic              in_range_s;

  // Address decode and asynchronous read
  always_comb begin
    offset_s = addr_i - BASE_W;
    // Addresses below the base wrap to huge offsets, so one unsigned
    // compare covers both the lower and the upper bound.
    in_range_s = (offset_s < SPAN_W);
    idx_s      = offset_s[IDX_W+1:2];
    if (in_range_s) begin
      rdata_o = mem_q[idx_s];
    end else begin
      rdata_o = {WORD_W{1'b0}};
    end
    in_range_o = in_range_s;
  end

  // Synchronous write port; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (write_en_i && in_range_s) begin
      mem_q[idx_s] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage ARM-subset pipeline.
// Performs LDR/STR accesses with a latency of ACCESS_LATENCY cycles.
// While an access is in flight, it freezes upstream and inserts bubbles into
// the MEM/WB register.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   wb_enable_in             : EXE/MEM writeback enable
//   mem_read_enable_in       : load request
//   mem_write_enable_in      : store request
//   alu_result_in            : effective byte address or ALU result
//   val_rm_in                : store data
//   dest_in                  : destination register
//   wb_enable_out            : MEM/WB writeback enable
//   mem_read_enable_out      : MEM/WB result select (1 = memory data)
//   alu_result_out           : MEM/WB ALU result
//   mem_data_out             : MEM/WB load data
//   dest_out                 : MEM/WB destination register
//   mem_freeze               : combinational freeze of IF/ID/EXE and the PC
//   addr_error               : sticky out-of-range access flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_WORDS      = 64,
  parameter int BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_enable_in,
  input  logic              mem_read_enable_in,
  input  logic              mem_write_enable_in,
  input  logic [WORD_W-1:0] alu_result_in,
  input  logic [WORD_W-1:0] val_rm_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              wb_enable_out,
  output logic              mem_read_enable_out,
  output logic [WORD_W-1:0] alu_result_out,
  output logic [WORD_W-1:0] mem_data_out,
  output logic [REG_W-1:0]  dest_out,
  output logic              mem_freeze,
  output logic              addr_error
);

  // The counter only has to hold ACCESS_LATENCY-2.
  localparam int                CNT_W     = $clog2(ACCESS_LATENCY + 1);
  localparam logic [WORD_W-1:0] ZERO_WORD = {WORD_W{1'b0}};
  localparam logic [REG_W-1:0]  ZERO_REG  = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0]  ZERO_CNT  = {CNT_W{1'b0}};

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              wb_enable_q, wb_enable_d;
  logic              mem_read_enable_q, mem_read_enable_d;
  logic [WORD_W-1:0] alu_result_q, alu_result_d;
  logic [WORD_W-1:0] mem_data_q, mem_data_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              addr_error_q, addr_error_d;

  logic              mem_op_s;
  logic              freeze_s;
  logic              complete_s;
  logic              mem_we_s;
  logic [WORD_W-1:0] rdata_s;
  logic              in_range_s;

  mem_stage_data_memory #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_data_memory (
    .clk        (clk),
    .write_en_i (mem_we_s),
    .addr_i     (alu_result_in),
    .wdata_i    (val_rm_in),
    .rdata_o    (rdata_s),
    .in_range_o (in_range_s)
  );

  // Access FSM: next state, countdown, freeze and completion strobe
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freeze_s   = 1'b0;
    complete_s = 1'b0;
    mem_op_s   = mem_read_enable_in | mem_write_enable_in;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          if (ACCESS_LATENCY == 1) begin
            complete_s = 1'b1;
          end else begin
            // The arrival cycle counts as the first stall cycle, so the
            // counter starts two below the latency.
            state_d  = ACCESS;
            cnt_d    = CNT_W'(ACCESS_LATENCY - 2);
            freeze_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q != ZERO_CNT) begin
          cnt_d    = cnt_q - CNT_W'(1);
          freeze_s = 1'b1;
        end else begin
          complete_s = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO_CNT;
      end
    endcase
  end

  // MEM/WB register next values, memory write strobe and sticky error flag
  always_comb begin
    // A reset in the final cycle must abort the store.
    mem_we_s     = complete_s & mem_write_enable_in & ~rst;
    addr_error_d = addr_error_q | (complete_s & ~in_range_s);
    if (freeze_s) begin
      wb_enable_d       = 1'b0;
      mem_read_enable_d = 1'b0;
      alu_result_d      = ZERO_WORD;
      mem_data_d        = ZERO_WORD;
      dest_d            = ZERO_REG;
    end else begin
      wb_enable_d       = wb_enable_in;
      mem_read_enable_d = mem_read_enable_in;
      alu_result_d      = alu_result_in;
      dest_d            = dest_in;
      // rdata_s is sampled before this edge's write lands, so a combined
      // read+write returns the old word.
      if (complete_s && mem_read_enable_in) begin
        mem_data_d = rdata_s;
      end else begin
        mem_data_d = ZERO_WORD;
      end
    end
  end

  // State, counter, MEM/WB register and error flag with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= ZERO_CNT;
      wb_enable_q       <= 1'b0;
      mem_read_enable_q <= 1'b0;
      alu_result_q      <= ZERO_WORD;
      mem_data_q        <= ZERO_WORD;
      dest_q            <= ZERO_REG;
      addr_error_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      wb_enable_q       <= wb_enable_d;
      mem_read_enable_q <= mem_read_enable_d;
      alu_result_q      <= alu_result_d;
      mem_data_q        <= mem_data_d;
      dest_q            <= dest_d;
      addr_error_q      <= addr_error_d;
    end
  end

  // Output mapping; the freeze is suppressed while reset is held
  always_comb begin
    wb_enable_out       = wb_enable_q;
    mem_read_enable_out = mem_read_enable_q;
    alu_result_out      = alu_result_q;
    mem_data_out        = mem_data_q;
    dest_out            = dest_q;
    addr_error          = addr_error_q;
    mem_freeze          = freeze_s & ~rst;
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // latency-4 instance
  logic        wb_in, rd_in, wr_in;
  logic [31:0] alu_in, rm_in;
  logic [3:0]  dest_in;
  logic        wb_out, rd_out, freeze, addr_err;
  logic [31:0] alu_out, data_out;
  logic [3:0]  dest_out;

  // latency-1 instance
  logic        l1_wb_in, l1_rd_in, l1_wr_in;
  logic [31:0] l1_alu_in, l1_rm_in;
  logic [3:0]  l1_dest_in;
  logic        l1_wb_out, l1_rd_out, l1_freeze, l1_addr_err;
  logic [31:0] l1_alu_out, l1_data_out;
  logic [3:0]  l1_dest_out;

  always #5 clk = ~clk;

  mem_stage #(.MEM_WORDS(64), .BASE_ADDR(1024), .ACCESS_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .wb_enable_in(wb_in), .mem_read_enable_in(rd_in), .mem_write_enable_in(wr_in),
    .alu_result_in(alu_in), .val_rm_in(rm_in), .dest_in(dest_in),
    .wb_enable_out(wb_out), .mem_read_enable_out(rd_out), .alu_result_out(alu_out),
    .mem_data_out(data_out), .dest_out(dest_out), .mem_freeze(freeze), .addr_error(addr_err)
  );

  mem_stage #(.MEM_WORDS(64), .BASE_ADDR(1024), .ACCESS_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .wb_enable_in(l1_wb_in), .mem_read_enable_in(l1_rd_in), .mem_write_enable_in(l1_wr_in),
    .alu_result_in(l1_alu_in), .val_rm_in(l1_rm_in), .dest_in(l1_dest_in),
    .wb_enable_out(l1_wb_out), .mem_read_enable_out(l1_rd_out), .alu_result_out(l1_alu_out),
    .mem_data_out(l1_data_out), .dest_out(l1_dest_out), .mem_freeze(l1_freeze),
    .addr_error(l1_addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic wb,
                       input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
    rd_in = rd; wr_in = wr; wb_in = wb; alu_in = addr; rm_in = data; dest_in = dest;
  endtask

  task automatic drive_l1(input logic rd, input logic wr, input logic wb,
                          input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
    l1_rd_in = rd; l1_wr_in = wr; l1_wb_in = wb; l1_alu_in = addr; l1_rm_in = data; l1_dest_in = dest;
  endtask

  // Called just after a rising edge. Runs a full access on the latency-4
  // instance and returns just after the completing edge, with inputs idle.
  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic wb,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
    drive(rd, wr, wb, addr, data, dest);
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check({tag, "_freeze_hi"}, 32'(freeze), 32'd1);
      @(posedge clk); #1;
      check({tag, "_bubble_wb"}, 32'(wb_out), 32'd0);
      check({tag, "_bubble_alu"}, alu_out, 32'd0);
    end
    @(negedge clk);
    check({tag, "_freeze_lo"}, 32'(freeze), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_l1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_wb", 32'(wb_out), 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_alu", alu_out, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_dest", 32'(dest_out), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);

    // latency-1 build: STR 7 to 1024 then LDR 1024 back to back
    drive_l1(1'b0, 1'b1, 1'b0, 32'd1024, 32'd7, 4'd0);
    @(negedge clk);
    check("l1_str_freeze", 32'(l1_freeze), 32'd0);
    @(posedge clk); #1;
    check("l1_str_alu", l1_alu_out, 32'd1024);
    drive_l1(1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd2);
    @(negedge clk);
    check("l1_ldr_freeze", 32'(l1_freeze), 32'd0);
    @(posedge clk); #1;
    check("l1_ldr_data", l1_data_out, 32'd7);
    check("l1_ldr_rd", 32'(l1_rd_out), 32'd1);
    check("l1_ldr_dest", 32'(l1_dest_out), 32'd2);
    drive_l1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // non-memory pass-through
    drive(1'b0, 1'b0, 1'b1, 32'h55, 32'd0, 4'd3);
    @(negedge clk);
    check("alu_freeze", 32'(freeze), 32'd0);
    @(posedge clk); #1;
    check("alu_result", alu_out, 32'h55);
    check("alu_dest", 32'(dest_out), 32'd3);
    check("alu_wb", 32'(wb_out), 32'd1);
    check("alu_data", data_out, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // store then load at latency 4
    mem_op("str1", 1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd5);
    check("str1_alu", alu_out, 32'd1028);
    check("str1_wb", 32'(wb_out), 32'd0);
    check("str1_dest", 32'(dest_out), 32'd5);
    check("str1_data", data_out, 32'd0);
    mem_op("ldr1", 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd6);
    check("ldr1_data", data_out, 32'hDEADBEEF);
    check("ldr1_rd", 32'(rd_out), 32'd1);
    check("ldr1_wb", 32'(wb_out), 32'd1);
    check("ldr1_dest", 32'(dest_out), 32'd6);
    check("ldr1_addr_err", 32'(addr_err), 32'd0);

    // out-of-range load, then out-of-range store
    mem_op("oor_ld", 1'b1, 1'b0, 1'b1, 32'd1280, 32'd0, 4'd1);
    check("oor_ld_data", data_out, 32'd0);
    check("oor_ld_err", 32'(addr_err), 32'd1);
    mem_op("oor_st", 1'b0, 1'b1, 1'b0, 32'd1000, 32'h99, 4'd0);
    check("oor_st_err", 32'(addr_err), 32'd1);
    mem_op("ldr2", 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd7);
    check("ldr2_data", data_out, 32'hDEADBEEF);
    check("ldr2_err_sticky", 32'(addr_err), 32'd1);

    // reset during the second freeze cycle of a store
    mem_op("str_old", 1'b0, 1'b1, 1'b0, 32'd1032, 32'h1111, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd1032, 32'h1234, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("mid_rst_freeze", 32'(freeze), 32'd0);
    check("mid_rst_wb", 32'(wb_out), 32'd0);
    check("mid_rst_alu", alu_out, 32'd0);
    check("mid_rst_data", data_out, 32'd0);
    check("mid_rst_err", 32'(addr_err), 32'd0);
    mem_op("ldr_old", 1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd4);
    check("ldr_old_data", data_out, 32'h1111);

    // misaligned store, aligned load, read+write
    mem_op("str_mis", 1'b0, 1'b1, 1'b0, 32'd1030, 32'hA, 4'd0);
    mem_op("ldr_al", 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd8);
    check("ldr_al_data", data_out, 32'hA);
    mem_op("rw", 1'b1, 1'b1, 1'b1, 32'd1028, 32'hB, 4'd9);
    check("rw_data_old", data_out, 32'hA);
    check("rw_rd", 32'(rd_out), 32'd1);
    mem_op("ldr_new", 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd10);
    check("ldr_new_data", data_out, 32'hB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
